// File: rtl/operand_writeback_if.sv
// ---------------------------------------------------------------------------
// operand_writeback_if
//
// Purpose: groups every signal of the write-back stage except clock and
// reset, so the stage, its upstream producer and the memory/register-file
// side connect through one bundle.
//
// Handshake (valid/ready): a request transfers on a rising clk edge where
// wb_valid and wb_ready are both high. The upstream stage holds wb_valid
// and all wb_* fields stable until that edge. A memory byte transfers on a
// rising clk edge where mem_we and mem_ready are both high; mem_ready is
// ignored while mem_we is low.
//
// Signals:
//   wb_valid/wb_ready            request handshake
//   wb_is_mem, wb_addr, wb_reg,
//   wb_byte, wb_sext, wb_data    destination descriptor and result
//   reg_we/reg_sel/reg_wmask/
//   reg_wdata                    register-file write port
//   mem_we/mem_addr/mem_wdata/
//   mem_ready                    byte-wide memory write port
//   wb_done, bus_err             completion / error pulses
//   dbg_state                    current FSM state encoding
//
// Modports: slave = the write-back stage, master = its environment.
// ---------------------------------------------------------------------------
interface operand_writeback_if #(
    parameter int ADDR_W = 16
);
    logic              wb_valid;
    logic              wb_ready;
    logic              wb_is_mem;
    logic [ADDR_W-1:0] wb_addr;
    logic [2:0]        wb_reg;
    logic              wb_byte;
    logic              wb_sext;
    logic [15:0]       wb_data;
    logic              reg_we;
    logic [2:0]        reg_sel;
    logic [1:0]        reg_wmask;
    logic [15:0]       reg_wdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ready;
    logic              wb_done;
    logic              bus_err;
    logic [2:0]        dbg_state;

    modport slave (
        input  wb_valid, wb_is_mem, wb_addr, wb_reg, wb_byte, wb_sext,
               wb_data, mem_ready,
        output wb_ready, reg_we, reg_sel, reg_wmask, reg_wdata,
               mem_we, mem_addr, mem_wdata, wb_done, bus_err, dbg_state
    );

    modport master (
        output wb_valid, wb_is_mem, wb_addr, wb_reg, wb_byte, wb_sext,
               wb_data, mem_ready,
        input  wb_ready, reg_we, reg_sel, reg_wmask, reg_wdata,
               mem_we, mem_addr, mem_wdata, wb_done, bus_err, dbg_state
    );
endinterface

// File: rtl/operand_writeback.sv
// ---------------------------------------------------------------------------
// operand_writeback
//
// Purpose: write-back stage of the PDP-11 core. Commits an ALU result to the
// register file or to byte-wide memory in big-endian order (addr holds
// [15:8], addr+1 holds [7:0]).
//
// Ports:
//   clk      core clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      operand_writeback_if.slave (request, register port, memory
//            port, done/error pulses, dbg_state)
//
// Parameters:
//   ADDR_W       memory address width; addr+1 wraps modulo 2^ADDR_W
//   MEM_TIMEOUT  cycles to wait for mem_ready on one byte before bus_err
//
// Build option:
//   ODD_ADDR_TRAP_EN  when defined, a word memory request to an odd address
//                     writes nothing and pulses bus_err the next cycle.
// ---------------------------------------------------------------------------
module operand_writeback #(
    parameter int ADDR_W      = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input logic                 clk,
    input logic                 reset_n,
    operand_writeback_if.slave  bus
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REG_WR = 3'd1,
        MEM_HI = 3'd2,
        MEM_LO = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t            state_q, state_d;
    // wb_is_mem is not stored: the state path taken already encodes it.
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        reg_q, reg_d;
    logic              byte_q, byte_d;
    logic              sext_q, sext_d;
    logic [15:0]       data_q, data_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bus_err_q, bus_err_d;
    logic              odd_trap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            reg_q       <= '0;
            byte_q      <= 1'b0;
            sext_q      <= 1'b0;
            data_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cnt_q       <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            reg_q       <= reg_d;
            byte_q      <= byte_d;
            sext_q      <= sext_d;
            data_q      <= data_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Memory outputs are computed one state ahead so that mem_we, mem_addr
    // and mem_wdata come straight from flops in the state that uses them.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        reg_d       = reg_q;
        byte_d      = byte_q;
        sext_d      = sext_q;
        data_d      = data_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        bus_err_d   = 1'b0;
        odd_trap    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.wb_valid) begin
                    addr_d = bus.wb_addr;
                    reg_d  = bus.wb_reg;
                    byte_d = bus.wb_byte;
                    sext_d = bus.wb_sext;
                    data_d = bus.wb_data;
                    cnt_d  = '0;
`ifdef ODD_ADDR_TRAP_EN
                    odd_trap = bus.wb_is_mem & ~bus.wb_byte & bus.wb_addr[0];
`else
                    odd_trap = 1'b0;
`endif
                    if (!bus.wb_is_mem) begin
                        state_d = REG_WR;
                    end else if (odd_trap) begin
                        // Nothing reaches memory; report and stay ready.
                        bus_err_d = 1'b1;
                        state_d   = IDLE;
                    end else if (bus.wb_byte) begin
                        state_d     = MEM_LO;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = bus.wb_addr;
                        mem_wdata_d = bus.wb_data[7:0];
                    end else begin
                        state_d     = MEM_HI;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = bus.wb_addr;
                        mem_wdata_d = bus.wb_data[15:8];
                    end
                end
            end

            REG_WR: state_d = FINISH;

            MEM_HI, MEM_LO: begin
                if (bus.mem_ready) begin
                    cnt_d = '0;
                    if (state_q == MEM_HI) begin
                        state_d     = MEM_LO;
                        mem_addr_d  = addr_q + ADDR_W'(1);
                        mem_wdata_d = data_q[7:0];
                    end else begin
                        state_d  = FINISH;
                        mem_we_d = 1'b0;
                    end
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    // This stalled cycle is the MEM_TIMEOUT-th one.
                    cnt_d     = '0;
                    mem_we_d  = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            FINISH: state_d = IDLE;

            default: begin
                state_d  = IDLE;
                mem_we_d = 1'b0;
            end
        endcase
    end

    logic reg_wr;
    assign reg_wr = (state_q == REG_WR);

    assign bus.wb_ready  = (state_q == IDLE);
    assign bus.reg_we    = reg_wr;
    assign bus.reg_sel   = reg_wr ? reg_q : 3'd0;
    // Byte writes without sign extension touch only the low byte.
    assign bus.reg_wmask = !reg_wr                ? 2'b00 :
                           (byte_q && !sext_q)    ? 2'b01 : 2'b11;
    assign bus.reg_wdata = !reg_wr ? 16'h0000 :
                           !byte_q ? data_q :
                           sext_q  ? {{8{data_q[7]}}, data_q[7:0]} :
                                     {8'h00, data_q[7:0]};
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.wb_done   = (state_q == FINISH);
    assign bus.bus_err   = bus_err_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_operand_writeback.sv
// Directed bench for operand_writeback. Inputs change at the falling edge
// (or 1 time unit after the rising edge); outputs are sampled at the
// falling edge. Cycle N is the accept cycle of each request.
module tb_operand_writeback;
    logic clk;
    logic reset_n;
    int   tests_run;
    int   tests_failed;

    operand_writeback_if #(.ADDR_W(16)) bus ();

    operand_writeback #(.ADDR_W(16), .MEM_TIMEOUT(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one request at a falling edge and lets it be accepted at the
    // next rising edge; returns 1 time unit into cycle N+1.
    task automatic issue(input logic is_mem, input logic [15:0] addr,
                         input logic [2:0] rg, input logic byt,
                         input logic sext, input logic [15:0] data);
        @(negedge clk);
        chk("ready_before_issue", {31'd0, bus.wb_ready}, 32'd1);
        bus.wb_valid  = 1'b1;
        bus.wb_is_mem = is_mem;
        bus.wb_addr   = addr;
        bus.wb_reg    = rg;
        bus.wb_byte   = byt;
        bus.wb_sext   = sext;
        bus.wb_data   = data;
        @(posedge clk);
        #1;
        bus.wb_valid  = 1'b0;
    endtask

    task automatic chk_mem(input string tag, input logic we,
                           input logic [15:0] addr, input logic [7:0] wdata);
        chk({tag, "_we"}, {31'd0, bus.mem_we}, {31'd0, we});
        if (we) begin
            chk({tag, "_addr"}, {16'd0, bus.mem_addr}, {16'd0, addr});
            chk({tag, "_wdata"}, {24'd0, bus.mem_wdata}, {24'd0, wdata});
        end
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        reset_n       = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_is_mem = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_reg    = '0;
        bus.wb_byte   = 1'b0;
        bus.wb_sext   = 1'b0;
        bus.wb_data   = '0;
        bus.mem_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.wb_ready}, 32'd1);
        chk("rst_reg_we", {31'd0, bus.reg_we}, 32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_done", {31'd0, bus.wb_done}, 32'd0);
        chk("rst_bus_err", {31'd0, bus.bus_err}, 32'd0);
        chk("rst_state", {29'd0, bus.dbg_state}, 32'd0);
        chk("rst_reg_wdata", {16'd0, bus.reg_wdata}, 32'd0);
        reset_n = 1'b1;

        // Register word write: R3 <= 16'o123456 (16'hA72E)
        issue(1'b0, 16'h0000, 3'd3, 1'b0, 1'b0, 16'o123456);
        @(negedge clk);
        chk("regw_we", {31'd0, bus.reg_we}, 32'd1);
        chk("regw_sel", {29'd0, bus.reg_sel}, 32'd3);
        chk("regw_mask", {30'd0, bus.reg_wmask}, 32'd3);
        chk("regw_wdata", {16'd0, bus.reg_wdata}, 32'h0000A72E);
        chk("regw_done_early", {31'd0, bus.wb_done}, 32'd0);
        chk("regw_mem_we", {31'd0, bus.mem_we}, 32'd0);
        @(negedge clk);
        chk("regw_done", {31'd0, bus.wb_done}, 32'd1);
        chk("regw_we_off", {31'd0, bus.reg_we}, 32'd0);

        // Register byte with sign extension: R2 <= 16'hFF85
        issue(1'b0, 16'h0000, 3'd2, 1'b1, 1'b1, 16'h0085);
        @(negedge clk);
        chk("regbs_sel", {29'd0, bus.reg_sel}, 32'd2);
        chk("regbs_mask", {30'd0, bus.reg_wmask}, 32'd3);
        chk("regbs_wdata", {16'd0, bus.reg_wdata}, 32'h0000FF85);
        @(negedge clk);
        chk("regbs_done", {31'd0, bus.wb_done}, 32'd1);

        // Register byte without sign extension: low byte only
        issue(1'b0, 16'h0000, 3'd2, 1'b1, 1'b0, 16'h0085);
        @(negedge clk);
        chk("regb_mask", {30'd0, bus.reg_wmask}, 32'd1);
        chk("regb_wdata", {16'd0, bus.reg_wdata}, 32'h00000085);
        @(negedge clk);
        chk("regb_done", {31'd0, bus.wb_done}, 32'd1);

        // Memory word with 3 stall cycles on the high byte
        bus.mem_ready = 1'b0;
        issue(1'b1, 16'h1000, 3'd0, 1'b0, 1'b0, 16'hBEEF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_mem("memw_hi", 1'b1, 16'h1000, 8'hBE);
            chk("memw_hi_done", {31'd0, bus.wb_done}, 32'd0);
            if (i == 3) bus.mem_ready = 1'b1;
        end
        @(negedge clk);
        chk_mem("memw_lo", 1'b1, 16'h1001, 8'hEF);
        chk("memw_lo_done", {31'd0, bus.wb_done}, 32'd0);
        @(negedge clk);
        chk("memw_done", {31'd0, bus.wb_done}, 32'd1);
        chk("memw_we_off", {31'd0, bus.mem_we}, 32'd0);
        @(negedge clk);
        chk("memw_done_pulse", {31'd0, bus.wb_done}, 32'd0);

        // Memory byte at an odd address: one write, then done
        issue(1'b1, 16'h2001, 3'd0, 1'b1, 1'b0, 16'h00A5);
        @(negedge clk);
        chk_mem("memb", 1'b1, 16'h2001, 8'hA5);
        @(negedge clk);
        chk("memb_done", {31'd0, bus.wb_done}, 32'd1);
        chk("memb_we_off", {31'd0, bus.mem_we}, 32'd0);

        // Word at 16'hFFFF: wraps to 16'h0000, or traps when enabled
        issue(1'b1, 16'hFFFF, 3'd0, 1'b0, 1'b0, 16'h1234);
`ifdef ODD_ADDR_TRAP_EN
        @(negedge clk);
        chk("trap_we", {31'd0, bus.mem_we}, 32'd0);
        chk("trap_bus_err", {31'd0, bus.bus_err}, 32'd1);
        chk("trap_done", {31'd0, bus.wb_done}, 32'd0);
        @(negedge clk);
        chk("trap_err_pulse", {31'd0, bus.bus_err}, 32'd0);
        chk("trap_done_after", {31'd0, bus.wb_done}, 32'd0);
`else
        @(negedge clk);
        chk_mem("wrap_hi", 1'b1, 16'hFFFF, 8'h12);
        @(negedge clk);
        chk_mem("wrap_lo", 1'b1, 16'h0000, 8'h34);
        @(negedge clk);
        chk("wrap_done", {31'd0, bus.wb_done}, 32'd1);
        chk("wrap_bus_err", {31'd0, bus.bus_err}, 32'd0);
`endif

        // Timeout: mem_ready never comes (MEM_TIMEOUT = 4)
        @(negedge clk);
        bus.mem_ready = 1'b0;
        issue(1'b1, 16'h3000, 3'd0, 1'b0, 1'b0, 16'h5566);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_mem("tmo_hi", 1'b1, 16'h3000, 8'h55);
            chk("tmo_err_early", {31'd0, bus.bus_err}, 32'd0);
        end
        @(negedge clk);
        chk("tmo_we_off", {31'd0, bus.mem_we}, 32'd0);
        chk("tmo_bus_err", {31'd0, bus.bus_err}, 32'd1);
        chk("tmo_ready", {31'd0, bus.wb_ready}, 32'd1);
        chk("tmo_done", {31'd0, bus.wb_done}, 32'd0);
        @(negedge clk);
        chk("tmo_err_pulse", {31'd0, bus.bus_err}, 32'd0);

        // Reset between high and low byte
        bus.mem_ready = 1'b1;
        issue(1'b1, 16'h4000, 3'd0, 1'b0, 1'b0, 16'hCAFE);
        @(negedge clk);
        chk_mem("rstmid_hi", 1'b1, 16'h4000, 8'hCA);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstmid_we_off", {31'd0, bus.mem_we}, 32'd0);
        chk("rstmid_state", {29'd0, bus.dbg_state}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstmid_no_done", {31'd0, bus.wb_done}, 32'd0);
            chk("rstmid_no_we", {31'd0, bus.mem_we}, 32'd0);
        end
        reset_n = 1'b1;

        // Fresh request after reset completes normally
        issue(1'b1, 16'h5000, 3'd0, 1'b1, 1'b0, 16'h125A);
        @(negedge clk);
        chk_mem("post_rst", 1'b1, 16'h5000, 8'h5A);
        @(negedge clk);
        chk("post_rst_done", {31'd0, bus.wb_done}, 32'd1);
        @(negedge clk);
        chk("post_rst_ready", {31'd0, bus.wb_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/operand_writeback.md
Name: operand_writeback

Overview:
- Write-back stage of the PDP-11 core, the write-side counterpart of the operand-fetch path.
- Takes an ALU result plus the destination descriptor produced at fetch time: mem/reg flag, effective address, register number and byte/word flag.
- Commits the result either to the register file or to byte-wide memory, using the core's big-endian byte order: addr holds [15:8], addr+1 holds [7:0].
- Sits between INSTRUCTION_EXECUTE and CHECK_END_OF_CODE in the top-level FSM (MEM_WRITE state).

Parameters:
- ADDR_W, 16, memory address width; addr+1 wraps modulo 2^ADDR_W.
- MEM_TIMEOUT, 255, maximum cycles to wait for mem_ready on one byte before bus_err.

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- wb_valid  in  1  write-back request valid.
- wb_ready  out  1  block can accept a request (high only in IDLE).
- wb_is_mem  in  1  1 = memory destination, 0 = register destination.
- wb_addr  in  ADDR_W  effective address when wb_is_mem=1.
- wb_reg  in  3  destination register R0-R7 (6 = SP, 7 = PC) when wb_is_mem=0.
- wb_byte  in  1  byte access.
- wb_sext  in  1  byte-to-register sign-extend (MOVB); ignored otherwise.
- wb_data  in  16  result.
- reg_we  out  1  register write strobe.
- reg_sel  out  3  register index.
- reg_wmask  out  2  byte enables, [1] = high byte, [0] = low byte.
- reg_wdata  out  16  register write data.
- mem_we  out  1  memory byte write request.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  8  memory byte data.
- mem_ready  in  1  memory accepted the byte this cycle.
- wb_done  out  1  one-cycle pulse when the write is committed.
- bus_err  out  1  one-cycle pulse on timeout (or odd trap); replaces wb_done.

Behaviour:
- Reset:
  - All outputs go to 0, except wb_ready = 1.
  - State goes to IDLE and the timeout counter clears.
  - Asynchronous reset mid-operation aborts the transfer. No further mem_we is issued and no wb_done is pulsed.
- States: IDLE, REG_WR, MEM_HI, MEM_LO, FINISH.
- IDLE:
  - wb_ready = 1.
  - On wb_valid & wb_ready, latch all wb_* inputs.
  - Next state: REG_WR if !wb_is_mem; MEM_LO if wb_is_mem & wb_byte; MEM_HI otherwise.
- REG_WR (exactly one cycle):
  - reg_we = 1, reg_sel = latched reg.
  - Word: reg_wmask = 11, reg_wdata = data.
  - Byte with sext: reg_wmask = 11, reg_wdata = {8{data[7]}, data[7:0]}.
  - Byte without sext: reg_wmask = 01, reg_wdata = {8'h00, data[7:0]}.
  - Next state: FINISH.
- MEM_HI (word only):
  - mem_we = 1, mem_addr = addr, mem_wdata = data[15:8].
  - Hold all three until mem_ready, then go to MEM_LO.
- MEM_LO:
  - mem_we = 1, mem_wdata = data[7:0].
  - mem_addr = addr for byte access; addr+1 (mod 2^ADDR_W, so 16'hFFFF -> 16'h0000) for word access.
  - Hold until mem_ready, then go to FINISH.
- Timeout:
  - The counter increments every cycle mem_we=1 & !mem_ready, and clears on each accepted byte.
  - When the counter reaches MEM_TIMEOUT: drop mem_we, pulse bus_err in the next cycle, return to IDLE, no wb_done.
  - If the high byte was already written, it stays written.
- FINISH: wb_done = 1 for one cycle, then IDLE.
- Latency (accept cycle = N):
  - Register write: reg_we in N+1, wb_done in N+2.
  - Memory write with zero-wait mem_ready: mem_we in N+1 (byte), or N+1 and N+2 (word); wb_done one cycle after the last accepted byte.
- mem_ready while mem_we=0 is ignored.
- wb_valid while not ready is ignored; the upstream stage must hold it.
- Back-to-back requests: a new request can be accepted the cycle after FINISH.
- mem_we, mem_addr and mem_wdata are registered outputs, stable for the whole request.

Optional Feature:
- Macro: ODD_ADDR_TRAP_EN.
- Defined: a word memory request with wb_addr[0]=1 performs no memory write. The block goes IDLE -> FINISH-equivalent error path and pulses bus_err in N+1, with no wb_done.
- Undefined: odd word addresses are written normally, addr then addr+1.
- Byte accesses are never trapped.

Test Plan:
- Reg word: wb_is_mem=0, reg=3, data=16'o123456 -> N+1: reg_we=1, reg_sel=3, reg_wmask=11, reg_wdata=16'o123456; N+2: wb_done=1.
- Reg byte sext: reg=2, byte=1, sext=1, data=16'h0085 -> reg_wdata=16'hFF85, reg_wmask=11; same with sext=0 -> reg_wdata=16'h0085, reg_wmask=01.
- Mem word, mem_ready stalled 3 cycles on the high byte: addr=16'h1000, data=16'hBEEF -> write 16'h1000=8'hBE held 4 cycles, then 16'h1001=8'hEF, then one wb_done.
- Mem byte plus wrap: byte at 16'h2001, data=16'h00A5 -> single write 16'h2001=8'hA5; word at 16'hFFFF -> writes 16'hFFFF then 16'h0000 (macro off); with ODD_ADDR_TRAP_EN defined -> no mem_we, bus_err=1.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_we high 4 cycles, then bus_err pulse, back to IDLE, wb_ready=1.
- Reset mid-word: assert reset_n=0 between the high and low byte -> mem_we=0 immediately, no wb_done; after release, a fresh request completes normally.
